multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- Instr  out  32  registered instruction to datapath
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a store
- dmem_ack  in  1  data access complete this cycle
- Zero  in  1  datapath ALU zero flag
- RegWrite  out  1  register file write enable
- ALUSrc  out  1  ALU operand B select: 0 register, 1 immediate
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- ResultSrc  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4
- ALUControl  out  4  ALU operation code
- pc_write  out  1  PC update strobe
- pc_src  out  1  PC next: 0 PC+4, 1 PC+immediate
- illegal  out  1  sticky illegal-opcode flag

Function
REQ-003 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-004 FETCH: imem_req=1 and held until imem_ack; on imem_ack, Instr<=imem_rdata and next state is DECODE; otherwise stay in FETCH.
REQ-005 DECODE: one cycle; opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (lw), 0100011 (sw), 1100011 (beq), 1101111 (jal) go to EXEC; any other opcode goes to TRAP.
REQ-006 ALUControl SHALL be ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, decoded from funct3 and funct7[5].
- For R-type, funct7[5] distinguishes SUB from ADD and SRA from SRL.
- For I-ALU, funct7[5] only selects SRA.
- lw, sw and jal use ADD; beq uses SUB.
REQ-007 ImmSrc, ALUSrc and ALUControl SHALL be valid from DECODE through the last state of the instruction.
- ALUSrc=1 for I-ALU, lw and sw; ALUSrc=0 otherwise.
REQ-008 EXEC transitions:
- R and I-ALU go to WB.
- lw and sw go to MEM.
- beq goes to FETCH with pc_write=1 and pc_src=Zero.
- jal goes to WB.
REQ-009 MEM: dmem_req=1 and dmem_we=(sw), held until dmem_ack.
- On ack, lw goes to WB.
- On ack, sw goes to FETCH with pc_write=1 and pc_src=0.
REQ-010 WB: RegWrite=1 for exactly one cycle, then next state is FETCH.
- pc_write=1 in WB.
- pc_src=1 for jal, 0 otherwise.
- ResultSrc=01 for lw, 10 for jal, 00 otherwise.
REQ-011 Exactly one pc_write pulse SHALL occur per retired instruction, and none in TRAP.
REQ-012 RegWrite, dmem_req and imem_req SHALL be 0 in every state other than those stated above.
REQ-013 TRAP: illegal=1 and all strobes 0; TRAP is exited only by reset.
REQ-014 A request held across wait cycles SHALL keep its outputs stable until the corresponding ack arrives.

Reset
REQ-015 While reset=0, the state SHALL be FETCH and all of the following SHALL be 0:
- Instr, RegWrite, ALUSrc, ImmSrc, ResultSrc, ALUControl
- pc_write, pc_src, dmem_req, dmem_we, illegal
- imem_req SHALL be 0 while reset is asserted.
REQ-016 Reset asserted mid-instruction SHALL abort the instruction immediately with no further strobes.
- The first cycle after release is FETCH with imem_req=1.

Verification
REQ-017 The bench SHALL cover the following scenarios:
- addi 00500093 with immediate acks -> the four states FETCH, DECODE, EXEC, WB occupy 4 cycles; ALUSrc=1, ImmSrc=00, ALUControl=0000; RegWrite=1 and pc_write=1 together in the single WB cycle.
- lw with dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=0 for 4 cycles; then WB with ResultSrc=01.
- sw -> MEM with dmem_we=1; pc_write=1 on the ack cycle; RegWrite never 1.
- beq with Zero=1 -> pc_src=1; with Zero=0 -> pc_src=0; ALUControl=0001, ImmSrc=10, RegWrite=0.
- Opcode 1111111 -> illegal=1 from the cycle after DECODE; no further imem_req until reset.
- Reset pulsed during MEM of lw -> dmem_req=0 immediately; RegWrite never asserted; FETCH resumes after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a sticky TRAP state.
// Operand controls are latched when the instruction is fetched. Strobes are decoded from the current state.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        Zero,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  ALUControl,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_BAD  = 3'd0,
        C_R    = 3'd1,
        C_I    = 3'd2,
        C_LW   = 3'd3,
        C_SW   = 3'd4,
        C_BEQ  = 3'd5,
        C_JAL  = 3'd6
    } cls_t;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] imm_src;
        logic [3:0] alu_ctl;
    } ctrl_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    function automatic cls_t classify(input logic [6:0] opcode);
        cls_t c;
        case (opcode)
            7'b0110011: c = C_R;
            7'b0010011: c = C_I;
            7'b0000011: c = C_LW;
            7'b0100011: c = C_SW;
            7'b1100011: c = C_BEQ;
            7'b1101111: c = C_JAL;
            default:    c = C_BAD;
        endcase
        return c;
    endfunction

    // funct7[5] only matters for SUB on R-type and for the arithmetic right shift.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic ctrl_t ctrl_decode(input logic [31:0] ins);
        ctrl_t r;
        r = '0;
        case (classify(ins[6:0]))
            C_R:     r = '{alu_src: 1'b0, imm_src: 2'b00, alu_ctl: alu_decode(ins[14:12], ins[30], 1'b1)};
            C_I:     r = '{alu_src: 1'b1, imm_src: 2'b00, alu_ctl: alu_decode(ins[14:12], ins[30], 1'b0)};
            C_LW:    r = '{alu_src: 1'b1, imm_src: 2'b00, alu_ctl: ALU_ADD};
            C_SW:    r = '{alu_src: 1'b1, imm_src: 2'b01, alu_ctl: ALU_ADD};
            C_BEQ:   r = '{alu_src: 1'b0, imm_src: 2'b10, alu_ctl: ALU_SUB};
            C_JAL:   r = '{alu_src: 1'b0, imm_src: 2'b11, alu_ctl: ALU_ADD};
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    cls_t        cls_q;
    ctrl_t       ctrl_q;
    logic [31:0] instr_q;
    logic        illegal_q;
    logic        fetch_done_s;

    assign fetch_done_s = (state_q == S_FETCH) && imem_ack;

    // State register; reset forces FETCH asynchronously, aborting any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction and its operand controls are captured together on the fetch acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= 32'h0000_0000;
            cls_q   <= C_BAD;
            ctrl_q  <= '0;
        end else if (fetch_done_s) begin
            instr_q <= imem_rdata;
            cls_q   <= classify(imem_rdata[6:0]);
            ctrl_q  <= ctrl_decode(imem_rdata);
        end else begin
            instr_q <= instr_q;
            cls_q   <= cls_q;
            ctrl_q  <= ctrl_q;
        end
    end

    // Sticky illegal flag, raised when DECODE rejects the opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else if ((state_q == S_DECODE) && (cls_q == C_BAD)) begin
            illegal_q <= 1'b1;
        end else begin
            illegal_q <= illegal_q;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = imem_ack ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (cls_q == C_BAD) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ:      state_d = S_FETCH;
                    C_R, C_I, C_JAL: state_d = S_WB;
                    default:    state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Per-state strobes; imem_req is gated by reset so nothing is requested while held in reset.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        RegWrite  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        ResultSrc = 2'b00;
        case (state_q)
            S_FETCH: imem_req = reset;
            S_EXEC: begin
                if (cls_q == C_BEQ) begin
                    pc_write = 1'b1;
                    pc_src   = Zero;
                end else begin
                    pc_write = 1'b0;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_SW);
                if (dmem_ack && (cls_q == C_SW)) begin
                    pc_write = 1'b1;
                end else begin
                    pc_write = 1'b0;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_write = 1'b1;
                pc_src   = (cls_q == C_JAL);
                case (cls_q)
                    C_LW:    ResultSrc = 2'b01;
                    C_JAL:   ResultSrc = 2'b10;
                    default: ResultSrc = 2'b00;
                endcase
            end
            default: imem_req = 1'b0;
        endcase
    end

    assign Instr      = instr_q;
    assign ALUSrc     = ctrl_q.alu_src;
    assign ImmSrc     = ctrl_q.imm_src;
    assign ALUControl = ctrl_q.alu_ctl;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues the expected retire record,
// the monitor builds the observed record on every pc_write pulse and compares.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_rdata, Instr;
    logic        dmem_req, dmem_we, dmem_ack, Zero;
    logic        RegWrite, ALUSrc, pc_write, pc_src, illegal;
    logic [1:0]  ImmSrc, ResultSrc;
    logic [3:0]  ALUControl;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  cycles;
        logic [3:0]  mem_cycles;
        logic        mem_we;
        logic [1:0]  rw_count;
        logic        pc_src;
        logic [1:0]  result_src;
        logic        alu_src;
        logic [1:0]  imm_src;
        logic [3:0]  alu_ctl;
    } rec_t;

    rec_t exp_q[$];

    multicycle_ctrl dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Instr(Instr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .Zero(Zero), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: track the instruction from its fetch acknowledge to its pc_write pulse.
    logic [3:0] m_cyc = 4'd0, m_mem = 4'd0;
    logic       m_we = 1'b0;
    logic [1:0] m_rw = 2'd0;
    always @(negedge clk) begin
        rec_t obs, exp_r;
        if (!reset) begin
            m_cyc = 4'd0; m_mem = 4'd0; m_we = 1'b0; m_rw = 2'd0;
        end else begin
            if (imem_req && imem_ack) begin
                m_cyc = 4'd1; m_mem = 4'd0; m_we = 1'b0; m_rw = 2'd0;
            end else begin
                m_cyc = m_cyc + 4'd1;
            end
            if (dmem_req) begin
                m_mem = m_mem + 4'd1;
                m_we  = m_we | dmem_we;
            end
            if (RegWrite) m_rw = m_rw + 2'd1;
            if (pc_write) begin
                obs = '{instr: Instr, cycles: m_cyc, mem_cycles: m_mem, mem_we: m_we,
                        rw_count: m_rw, pc_src: pc_src, result_src: ResultSrc,
                        alu_src: ALUSrc, imm_src: ImmSrc, alu_ctl: ALUControl};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_retire: got %0h expected none", obs);
                end else begin
                    exp_r = exp_q.pop_front();
                    check($sformatf("retire_%08h", exp_r.instr), 64'(obs), 64'(exp_r));
                end
            end
        end
    end

    // Fetch one instruction, then service data accesses until the control unit is back in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int iwait, input int dwait,
                             input logic z, input rec_t exp_r);
        int dcnt = 0;
        bit done = 0;
        exp_q.push_back(exp_r);
        Zero = z;
        repeat (iwait) begin
            imem_ack = 1'b0;
            @(posedge clk); #1;
        end
        imem_ack = 1'b1; imem_rdata = ins;
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) begin
                done = 1;
                break;
            end
            if (dmem_req) begin
                dmem_ack = (dcnt == dwait);
                dcnt++;
            end else begin
                dmem_ack = 1'b0;
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout_%08h: got no return to FETCH expected FETCH within 40 cycles", ins);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] ins, input int cyc, input int mem, input logic we,
                                input int rw, input logic ps, input logic [1:0] rs,
                                input logic as, input logic [1:0] is, input logic [3:0] ac);
        return '{instr: ins, cycles: 4'(cyc), mem_cycles: 4'(mem), mem_we: we, rw_count: 2'(rw),
                 pc_src: ps, result_src: rs, alu_src: as, imm_src: is, alu_ctl: ac};
    endfunction

    initial begin
        int bad;
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; dmem_ack = 1'b0; Zero = 1'b0;
        #12;
        check("reset_outputs",
              64'({Instr, imem_req, dmem_req, dmem_we, RegWrite, ALUSrc, ImmSrc, ResultSrc,
                   ALUControl, pc_write, pc_src, illegal}), 64'h0);
        @(negedge clk); reset = 1'b1; #1;
        check("release_imem_req", 64'(imem_req), 64'h1);
        @(posedge clk); #1;

        run_instr(32'h00500093, 0, 0, 1'b0, mk(32'h00500093, 4, 0, 1'b0, 1, 1'b0, 2'b00, 1'b1, 2'b00, 4'b0000));
        run_instr(32'h002081b3, 2, 0, 1'b0, mk(32'h002081b3, 4, 0, 1'b0, 1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000));
        run_instr(32'h402081b3, 0, 0, 1'b0, mk(32'h402081b3, 4, 0, 1'b0, 1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0001));
        run_instr(32'h0020e1b3, 0, 0, 1'b0, mk(32'h0020e1b3, 4, 0, 1'b0, 1, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0011));
        run_instr(32'h4010d093, 0, 0, 1'b0, mk(32'h4010d093, 4, 0, 1'b0, 1, 1'b0, 2'b00, 1'b1, 2'b00, 4'b1000));
        run_instr(32'h40008093, 0, 0, 1'b0, mk(32'h40008093, 4, 0, 1'b0, 1, 1'b0, 2'b00, 1'b1, 2'b00, 4'b0000));
        run_instr(32'h0000a103, 0, 3, 1'b0, mk(32'h0000a103, 8, 4, 1'b0, 1, 1'b0, 2'b01, 1'b1, 2'b00, 4'b0000));
        run_instr(32'h0020a023, 1, 1, 1'b0, mk(32'h0020a023, 5, 2, 1'b1, 0, 1'b0, 2'b00, 1'b1, 2'b01, 4'b0000));
        run_instr(32'h00208463, 0, 0, 1'b1, mk(32'h00208463, 3, 0, 1'b0, 0, 1'b1, 2'b00, 1'b0, 2'b10, 4'b0001));
        run_instr(32'h00208463, 0, 0, 1'b0, mk(32'h00208463, 3, 0, 1'b0, 0, 1'b0, 2'b00, 1'b0, 2'b10, 4'b0001));
        run_instr(32'h008000ef, 0, 0, 1'b0, mk(32'h008000ef, 4, 0, 1'b0, 1, 1'b1, 2'b10, 1'b0, 2'b11, 4'b0000));

        // Illegal opcode: flag rises the cycle after DECODE and the unit stays silent.
        imem_ack = 1'b1; imem_rdata = 32'h0000007f;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check("illegal_in_decode", 64'(illegal), 64'h0);
        @(posedge clk); #1;
        check("illegal_after_decode", 64'(illegal), 64'h1);
        bad = 0;
        repeat (10) begin
            if (imem_req || dmem_req || RegWrite || pc_write || !illegal) bad++;
            @(posedge clk); #1;
        end
        check("trap_silent", 64'(bad), 64'h0);
        #2 reset = 1'b0; #1;
        check("trap_reset_clears", 64'({illegal, imem_req}), 64'h0);
        @(negedge clk); reset = 1'b1; #1;
        check("trap_release_fetch", 64'(imem_req), 64'h1);
        @(posedge clk); #1;

        // Reset during MEM of a load aborts it with no write-back.
        imem_ack = 1'b1; imem_rdata = 32'h0000a103;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        for (int i = 0; i < 10 && !dmem_req; i++) begin
            @(posedge clk); #1;
        end
        check("abort_in_mem", 64'(dmem_req), 64'h1);
        @(posedge clk); #1;
        #2 reset = 1'b0; #1;
        check("abort_strobes", 64'({dmem_req, dmem_we, RegWrite, pc_write, imem_req}), 64'h0);
        check("abort_instr_cleared", 64'(Instr), 64'h0);
        bad = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (RegWrite || dmem_req) bad++;
        end
        @(negedge clk); reset = 1'b1; #1;
        check("abort_release_fetch", 64'(imem_req), 64'h1);
        @(posedge clk); #1;
        if (RegWrite) bad++;
        check("abort_no_regwrite", 64'(bad), 64'h0);

        run_instr(32'h00500093, 0, 0, 1'b0, mk(32'h00500093, 4, 0, 1'b0, 1, 1'b0, 2'b00, 1'b1, 2'b00, 4'b0000));
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
